// File: rtl/seq_mult_if.sv
// seq_mult_if
//   Operand/result channel between the operand-loading controller and the
//   sequential multiplier.
//
//   Handshake: the controller (master) raises start for one clock, with
//   is_signed/a/b valid in that same clock. The multiplier accepts it only
//   when busy is low (IDLE). A start seen while busy is high is dropped, not
//   queued. The multiplier (slave) raises done for exactly one clock when
//   product is valid, and product holds until the next result is written.
//   There is no back-pressure: the controller must take product while done
//   is high or read the held value later.
//
// Signals:
//   start      master->slave  request a multiply (1-cycle pulse)
//   is_signed  master->slave  1 = two's-complement operands
//   a, b       master->slave  multiplicand / multiplier, WIDTH bits
//   busy       slave->master  operation in progress
//   done       slave->master  1-cycle pulse, product valid
//   product    slave->master  2*WIDTH-bit result
interface seq_mult_if #(
   parameter int WIDTH = 16
);
   logic                   start;
   logic                   is_signed;
   logic [WIDTH-1:0]       a;
   logic [WIDTH-1:0]       b;
   logic                   busy;
   logic                   done;
   logic [2*WIDTH-1:0]     product;

   modport master (
      output start, is_signed, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, is_signed, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/seq_mult_unit.sv
// seq_mult_unit
//   Radix-2 shift-add multiplier, one partial product per clock. Signed
//   operands are reduced to magnitudes, multiplied unsigned, and the result
//   is negated at the end when the operand signs differ.
//   Latency is WIDTH+1 clocks from the accepting start edge to done.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low
//   bus          seq_mult_if slave side (start/is_signed/a/b in,
//                busy/done/product out)
//   debug_state  current FSM state (0 IDLE, 1 CALC, 2 FIX)
module seq_mult_unit #(
   parameter int WIDTH = 16
) (
   input  logic        clock,
   input  logic        reset,
   seq_mult_if.slave   bus,
   output logic [1:0]  debug_state
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;

   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;
   logic                 neg;
   // Upper WIDTH+1 bits hold the running sum plus its carry; the lower
   // WIDTH bits collect finished product bits as the register shifts right.
   logic [2*WIDTH:0]     acc;
   logic [CW-1:0]        count;
   logic                 done_q;
   logic [2*WIDTH-1:0]   product_q;

   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [WIDTH:0]       hi_sum;
   logic [2*WIDTH-1:0]   result;

   // Operand conditioning and per-step arithmetic.
   always_comb begin
      a_mag  = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      b_mag  = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      // After every shift acc[2*WIDTH] is 0, so this sum cannot overflow.
      hi_sum = acc[2*WIDTH:WIDTH] + (mplier[0] ? {1'b0, mcand} : '0);
      // Negating zero gives zero, so no special case for a zero product.
      result = neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (bus.start) state_next = S_CALC;
         S_CALC:  if (count == CW'(1)) state_next = S_FIX;
         S_FIX:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Datapath.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mcand     <= '0;
         mplier    <= '0;
         neg       <= 1'b0;
         acc       <= '0;
         count     <= '0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  acc    <= '0;
                  count  <= CW'(WIDTH);
               end
            end
            S_CALC: begin
               acc    <= {1'b0, hi_sum, acc[WIDTH-1:1]};
               mplier <= mplier >> 1;
               count  <= count - CW'(1);
            end
            S_FIX: begin
               product_q <= result;
               done_q    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = (state != S_IDLE);
   assign bus.done    = done_q;
   assign bus.product = product_q;
   assign debug_state = state;

endmodule

// File: tb/tb_seq_mult_unit.sv
// tb_seq_mult_unit
//   Directed bench for seq_mult_unit at WIDTH=16 with hand-computed vectors.
module tb_seq_mult_unit;

   localparam int W = 16;

   logic       clock;
   logic       reset;
   logic [1:0] debug_state;

   int tests;
   int fails;

   seq_mult_if #(.WIDTH(W)) bus ();

   seq_mult_unit #(.WIDTH(W)) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .debug_state (debug_state)
   );

   // Clock and reset.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one start, optionally scramble operands after the start edge,
   // then check latency, busy duration, product, the done pulse width and
   // that product holds afterwards.
   task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input logic scramble,
                         input logic [2*W-1:0] exp);
      int cyc;
      int busy_cnt;
      bus.start     = 1'b1;
      bus.is_signed = sgn;
      bus.a         = aa;
      bus.b         = bb;
      tick();
      bus.start = 1'b0;
      if (scramble) begin
         bus.a         = 16'hAAAA;
         bus.b         = 16'hAAAA;
         bus.is_signed = ~sgn;
      end
      cyc      = 0;
      busy_cnt = bus.busy ? 1 : 0;
      while (!bus.done && cyc < 40) begin
         tick();
         cyc++;
         if (bus.busy) busy_cnt++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(W + 1));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
      check({tag, "_product"}, bus.product, exp);
      tick();
      check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
      tick();
      check({tag, "_hold"}, bus.product, exp);
   endtask

   initial begin
      int n_done;
      int d1;
      int d2;
      logic [2*W-1:0] p1;
      logic [2*W-1:0] p2;

      tests         = 0;
      fails         = 0;
      reset         = 1'b0;
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.a         = '0;
      bus.b         = '0;

      repeat (3) tick();
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      check("reset_done", {31'd0, bus.done}, 32'd0);
      check("reset_product", bus.product, 32'd0);
      check("reset_state", {30'd0, debug_state}, 32'd0);
      reset = 1'b1;
      tick();

      // Main function.
      run_op("u_ffff_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
      run_op("s_m3_5",      1'b1, 16'hFFFD, 16'h0005, 1'b0, 32'hFFFFFFF1);
      run_op("s_min_min",   1'b1, 16'h8000, 16'h8000, 1'b0, 32'h40000000);
      run_op("s_min_1",     1'b1, 16'h8000, 16'h0001, 1'b0, 32'hFFFF8000);
      run_op("s_max_min",   1'b1, 16'h7FFF, 16'h8000, 1'b0, 32'hC0008000);
      run_op("s_m1_0",      1'b1, 16'hFFFF, 16'h0000, 1'b0, 32'h00000000);
      run_op("u_1_1234",    1'b0, 16'h0001, 16'h1234, 1'b0, 32'h00001234);
      run_op("u_ffff_2",    1'b0, 16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE);

      // Start while busy is dropped; start during the done cycle is taken.
      bus.start     = 1'b1;
      bus.is_signed = 1'b0;
      bus.a         = 16'd3;
      bus.b         = 16'd4;
      tick();
      bus.start = 1'b0;
      n_done = 0;
      d1     = 0;
      d2     = 0;
      p1     = '0;
      p2     = '0;
      for (int k = 1; k <= 60; k++) begin
         if (k == 5) begin
            bus.start = 1'b1;
            bus.a     = 16'd7;
            bus.b     = 16'd7;
         end
         if (k == 18) begin
            check("busy_done_at_restart", {31'd0, bus.done}, 32'd1);
            bus.start = 1'b1;
            bus.a     = 16'd7;
            bus.b     = 16'd7;
         end
         tick();
         bus.start = 1'b0;
         if (bus.done) begin
            n_done++;
            if (n_done == 1) begin
               d1 = k;
               p1 = bus.product;
            end else if (n_done == 2) begin
               d2 = k;
               p2 = bus.product;
            end
         end
      end
      check("busy_first_done_edge", 32'(d1), 32'd17);
      check("busy_first_product", p1, 32'd12);
      check("busy_second_done_edge", 32'(d2), 32'd35);
      check("busy_second_product", p2, 32'd49);
      check("busy_done_count", 32'(n_done), 32'd2);

      // Operands and mode change right after the start edge.
      run_op("scramble_2_9", 1'b0, 16'd2, 16'd9, 1'b1, 32'd18);

      // Reset in the middle of an operation.
      bus.start     = 1'b1;
      bus.is_signed = 1'b0;
      bus.a         = 16'h1234;
      bus.b         = 16'h5678;
      tick();
      bus.start = 1'b0;
      repeat (8) tick();
      check("midop_busy_before", {31'd0, bus.busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("midop_busy", {31'd0, bus.busy}, 32'd0);
      check("midop_done", {31'd0, bus.done}, 32'd0);
      check("midop_product", bus.product, 32'd0);
      check("midop_state", {30'd0, debug_state}, 32'd0);
      tick();
      reset = 1'b1;
      n_done = 0;
      for (int k = 0; k < 25; k++) begin
         tick();
         if (bus.done) n_done++;
      end
      check("midop_no_done", 32'(n_done), 32'd0);
      run_op("after_reset_6_7", 1'b0, 16'd6, 16'd7, 1'b0, 32'd42);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
